// File: rtl/arm7tdmi_pkg.sv
// arm7tdmi_pkg: shared types for the ARM7TDMI multiplier controller.
//   mul_op_e    : 3-bit op encoding {accumulate, long, signed}
//   mul_state_e : controller FSM states
//   MUL_CHUNK_W : multiplier bits retired per MULT cycle
package arm7tdmi_pkg;

  localparam int MUL_CHUNK_W = 8;

  // Bit positions inside mul_op_e
  localparam int OP_ACC_BIT    = 2;
  localparam int OP_LONG_BIT   = 1;
  localparam int OP_SIGNED_BIT = 0;

  typedef enum logic [2:0] {
    OP_MUL   = 3'b000,
    OP_MULS  = 3'b001,
    OP_UMULL = 3'b010,
    OP_SMULL = 3'b011,
    OP_MLA   = 3'b100,
    OP_MLAS  = 3'b101,
    OP_UMLAL = 3'b110,
    OP_SMLAL = 3'b111
  } mul_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MULT,
    S_ACC,
    S_HI,
    S_DONE
  } mul_state_e;

endpackage

// File: rtl/arm7tdmi_mul_step.sv
// arm7tdmi_mul_step: one combinational multiply iteration.
//   p_out = p_in + ((a_ext * chunk) << (CHUNK_W*idx)), mod 2^64.
// Ports:
//   p_in         : running 64-bit partial product
//   a_ext        : multiplicand already extended to 64 bits
//   chunk        : current multiplier chunk
//   chunk_signed : treat chunk as two's complement (final chunk of signed-rule ops)
//   idx          : iteration index (selects the shift)
//   p_out        : updated partial product
module arm7tdmi_mul_step #(
  parameter int CHUNK_W = 8,
  parameter int IDX_W   = 2
) (
  input  logic [63:0]        p_in,
  input  logic [63:0]        a_ext,
  input  logic [CHUNK_W-1:0] chunk,
  input  logic               chunk_signed,
  input  logic [IDX_W-1:0]   idx,
  output logic [63:0]        p_out
);

  logic [63:0] chunk_ext;
  logic [63:0] prod;

  always_comb begin
    chunk_ext = {{(64-CHUNK_W){chunk_signed & chunk[CHUNK_W-1]}}, chunk};
    prod      = a_ext * chunk_ext;
    p_out     = p_in + (prod << (int'(idx) * CHUNK_W));
  end

endmodule

// File: rtl/arm7tdmi_mul_ctrl.sv
// arm7tdmi_mul_ctrl: iterative MUL/MLA/UMULL/UMLAL/SMULL/SMLAL controller.
// Retires CHUNK_W multiplier bits per MULT cycle, optionally accumulates,
// spends one HI cycle for long ops, then pulses done with the result.
// Ports:
//   clk, rst             : clock, async active-high reset
//   start, op            : request (taken in IDLE) and op kind
//   op_a, op_b           : multiplicand (Rm), multiplier (Rs)
//   acc_lo, acc_hi       : accumulate addend
//   abort                : flush, cancels in-flight op without done
//   busy, done           : not-IDLE, one-cycle completion pulse
//   result_lo/hi, flag_n/z : product and N/Z, held between ops
// Config macro: ARM_MUL_EARLY_TERM_EN enables early termination of MULT.
module arm7tdmi_mul_ctrl
  import arm7tdmi_pkg::*;
#(
  parameter int CHUNK_W = MUL_CHUNK_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  mul_op_e     op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] acc_lo,
  input  logic [31:0] acc_hi,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [31:0] result_lo,
  output logic [31:0] result_hi,
  output logic        flag_n,
  output logic        flag_z
);

  localparam int NCH   = 32 / CHUNK_W;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NCH - 1);

  mul_state_e        state_q, state_d;
  mul_op_e           op_q, op_d;
  logic [31:0]       a_q, a_d, b_q, b_d, acc_lo_q, acc_lo_d, acc_hi_q, acc_hi_d;
  logic [63:0]       p_q, p_d;
  logic [IDX_W-1:0]  i_q, i_d;
  logic              done_q, done_d;
  logic [31:0]       res_lo_q, res_lo_d, res_hi_q, res_hi_d;
  logic              flag_n_q, flag_n_d, flag_z_q, flag_z_d;

  logic              is_acc, is_long, is_signed, signed_rule;
  logic [63:0]       a_ext, acc_add, step_p;
  logic [CHUNK_W-1:0] chunk;
  logic              early, last_iter;

  always_comb begin
    is_acc      = op_q[OP_ACC_BIT];
    is_long     = op_q[OP_LONG_BIT];
    is_signed   = op_q[OP_SIGNED_BIT];
    // Short ops only keep the low word, so they may use the signed rule freely.
    signed_rule = is_signed | ~is_long;
    a_ext       = is_signed ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
    chunk       = CHUNK_W'(b_q >> (int'(i_q) * CHUNK_W));
    acc_add     = is_long ? {acc_hi_q, acc_lo_q} : {32'b0, acc_lo_q};
  end

`ifdef ARM_MUL_EARLY_TERM_EN
  logic signed [31:0] sb;
  logic        [31:0] ub;
  always_comb begin
    // sb covers b[31 : CHUNK_W*(i+1)-1]: the remaining bits plus this chunk's MSB.
    sb    = $signed(b_q) >>> (int'(i_q) * CHUNK_W + CHUNK_W - 1);
    ub    = b_q >> ((int'(i_q) + 1) * CHUNK_W);
    early = signed_rule ? ((sb == '0) || (sb == '1)) : (ub == '0);
  end
`else
  assign early = 1'b0;
`endif

  assign last_iter = (i_q == LAST) || early;

  arm7tdmi_mul_step #(.CHUNK_W(CHUNK_W), .IDX_W(IDX_W)) u_step (
    .p_in        (p_q),
    .a_ext       (a_ext),
    .chunk       (chunk),
    .chunk_signed(signed_rule & last_iter),
    .idx         (i_q),
    .p_out       (step_p)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_lo_d = acc_lo_q;
    acc_hi_d = acc_hi_q;
    p_d      = p_q;
    i_d      = i_q;
    case (state_q)
      S_IDLE: if (start && !abort) begin
        op_d     = op;
        a_d      = op_a;
        b_d      = op_b;
        acc_lo_d = acc_lo;
        acc_hi_d = acc_hi;
        p_d      = '0;
        i_d      = '0;
        state_d  = S_MULT;
      end
      S_MULT: begin
        p_d = step_p;
        i_d = i_q + IDX_W'(1);
        if (last_iter)
          state_d = is_acc ? S_ACC : (is_long ? S_HI : S_DONE);
      end
      S_ACC: begin
        p_d     = p_q + acc_add;
        state_d = is_long ? S_HI : S_DONE;
      end
      S_HI:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) state_d = S_IDLE;

    // Result registers load on entry to DONE so they are valid during it.
    done_d   = (state_d == S_DONE);
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    flag_n_d = flag_n_q;
    flag_z_d = flag_z_q;
    if (done_d) begin
      res_lo_d = p_d[31:0];
      res_hi_d = is_long ? p_d[63:32] : 32'b0;
      flag_n_d = is_long ? p_d[63] : p_d[31];
      flag_z_d = is_long ? (p_d == '0) : (p_d[31:0] == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MUL;
      a_q      <= '0;
      b_q      <= '0;
      acc_lo_q <= '0;
      acc_hi_q <= '0;
      p_q      <= '0;
      i_q      <= '0;
      done_q   <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      flag_n_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_lo_q <= acc_lo_d;
      acc_hi_q <= acc_hi_d;
      p_q      <= p_d;
      i_q      <= i_d;
      done_q   <= done_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      flag_n_q <= flag_n_d;
      flag_z_q <= flag_z_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign result_lo = res_lo_q;
  assign result_hi = res_hi_q;
  assign flag_n    = flag_n_q;
  assign flag_z    = flag_z_q;

endmodule

// File: tb/tb_arm7tdmi_mul_ctrl.sv
// tb_arm7tdmi_mul_ctrl: directed self-checking bench for arm7tdmi_mul_ctrl.
// Cycle numbering: cycle 0 is the cycle start is high; done for a MUL that
// finishes in one MULT iteration shows up in cycle 2.
module tb_arm7tdmi_mul_ctrl;
  import arm7tdmi_pkg::*;

`ifdef ARM_MUL_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  mul_op_e     op = OP_MUL;
  logic [31:0] op_a = '0, op_b = '0, acc_lo = '0, acc_hi = '0;
  logic        busy, done, flag_n, flag_z;
  logic [31:0] result_lo, result_hi;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  arm7tdmi_mul_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .op_a     (op_a),
    .op_b     (op_b),
    .acc_lo   (acc_lo),
    .acc_hi   (acc_hi),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .result_lo(result_lo),
    .result_hi(result_hi),
    .flag_n   (flag_n),
    .flag_z   (flag_z)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one op, count cycles to done, check result/flags and the
  // one-cycle done pulse. inj_cyc > 0 re-pulses start in that busy cycle.
  task automatic run(input string tag, input mul_op_e o, input logic [31:0] a, b, al, ah,
                     input int exp_cyc, input logic [63:0] exp_res,
                     input logic en, ez, input int inj_cyc);
    int cyc;
    bit got;
    @(negedge clk);
    op = o; op_a = a; op_b = b; acc_lo = al; acc_hi = ah; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == 1) chk({tag, ".busy"}, 64'(busy), 64'd1);
      if (done) got = 1'b1;
      else if (cyc == inj_cyc) begin
        op = OP_MUL; op_a = 32'd1; op_b = 32'd1; start = 1'b1;
      end
    end
    chk({tag, ".lat"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, ".res"}, {result_hi, result_lo}, exp_res);
    chk({tag, ".n"}, 64'(flag_n), 64'(en));
    chk({tag, ".z"}, 64'(flag_z), 64'(ez));
    @(negedge clk);
    chk({tag, ".done_off"}, 64'(done), 64'd0);
    chk({tag, ".idle"}, 64'(busy), 64'd0);
    chk({tag, ".hold"}, {result_hi, result_lo}, exp_res);
  endtask

  initial begin
    bit seen;
    int acc_cyc;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.res", {result_hi, result_lo}, 64'd0);
    chk("rst.nz", {62'd0, flag_n, flag_z}, 64'd0);
    rst = 1'b0;

    run("mul", OP_MUL, 32'd5, 32'd7, 32'd0, 32'd0, ET ? 2 : 5, 64'd35, 1'b0, 1'b0, 0);
    run("mla", OP_MLA, 32'd5, 32'd7, 32'd35, 32'd0, ET ? 3 : 6, 64'd70, 1'b0, 1'b0, 0);
    run("mulz", OP_MUL, 32'd0, 32'd9, 32'd0, 32'd0, ET ? 2 : 5, 64'd0, 1'b0, 1'b1, 0);
    run("umull_ffff", OP_UMULL, 32'h0000FFFF, 32'h0000FFFF, 32'd0, 32'd0, ET ? 4 : 6,
        64'h00000000_FFFE0001, 1'b0, 1'b0, 0);
    run("smull_m1m2", OP_SMULL, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd0, 32'd0, ET ? 3 : 6,
        64'h00000000_00000002, 1'b0, 1'b0, 0);
    run("umull_m1m2", OP_UMULL, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd0, 32'd0, 6,
        64'hFFFFFFFD_00000002, 1'b1, 1'b0, 0);
    run("smlal", OP_SMLAL, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, ET ? 6 : 7,
        64'h00000000_FFFE0000, 1'b0, 1'b0, 0);

    // Abort during MULT: back to IDLE next cycle, no done, outputs held
    @(negedge clk);
    op = OP_UMULL; op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFE; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort.busy", 64'(busy), 64'd0);
    chk("abort.done", 64'(done), 64'd0);
    chk("abort.hold", {result_hi, result_lo}, 64'h00000000_FFFE0000);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("abort.nodone", 64'(seen), 64'd0);

    // start while busy (cycle 2) must not disturb the running UMULL
    run("busy_start", OP_UMULL, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd0, 32'd0, 6,
        64'hFFFFFFFD_00000002, 1'b1, 1'b0, 2);

    // Reset asserted while in ACC clears everything immediately
    acc_cyc = ET ? 2 : 5;
    @(negedge clk);
    op = OP_MLA; op_a = 32'd5; op_b = 32'd7; acc_lo = 32'd35; acc_hi = 32'd0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (acc_cyc) @(negedge clk);
    chk("racc.busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("racc.busy", 64'(busy), 64'd0);
    chk("racc.done", 64'(done), 64'd0);
    chk("racc.res", {result_hi, result_lo}, 64'd0);
    chk("racc.nz", {62'd0, flag_n, flag_z}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run("mul_after_rst", OP_MUL, 32'd5, 32'd7, 32'd0, 32'd0, ET ? 2 : 5, 64'd35, 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/arm7tdmi_mul_ctrl.md
ARM7TDMI_MUL_CTRL -- requirements
Module: arm7tdmi_mul_ctrl

Interface
REQ-001 SHALL have parameter CHUNK_W, default 8, multiplier bits retired per iteration cycle.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 start  input  1  request; accepted only in IDLE.
REQ-005 op  input  mul_op_e (3)  {accumulate, long, signed}.
REQ-006 op_a  input  32  multiplicand (Rm).
REQ-007 op_b  input  32  multiplier (Rs).
REQ-008 acc_lo / acc_hi  input  32 each  accumulate addend (RdLo/Rn, RdHi).
REQ-009 abort  input  1  pipeline flush; cancels the operation in flight.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse; results valid that cycle only.
REQ-012 result_lo / result_hi  output  32 each  product; result_hi = 0 for short ops.
REQ-013 flag_n / flag_z  output  1 each  N and Z of the result.

Function
REQ-014 SHALL use states IDLE, MULT, ACC, HI, DONE.
REQ-015 IDLE and start: SHALL latch op, op_a, op_b, acc_lo, acc_hi, clear the 64-bit accumulator P, set iteration i=0, and go to MULT.
REQ-016 MULT: each cycle SHALL set P += (A * chunk_i) << (8*i), chunk_i = op_b[8i+7:8i], A = op_a sign-extended to 64 bits if signed, else zero-extended; arithmetic is mod 2^64.
REQ-017 MULT SHALL end after iteration i when i=3 or an early-termination condition holds. Signed (and all short ops): op_b[31:8(i+1)] all equal op_b[8i+7]. Unsigned long: op_b[31:8(i+1)] all zero.
REQ-018 The final chunk of a signed-rule op SHALL be treated as two's-complement signed; all other chunks are unsigned.
REQ-019 After MULT, the FSM SHALL go to ACC if accumulate, else HI if long, else DONE.
REQ-020 ACC SHALL add {acc_hi,acc_lo} (long) or {32'b0,acc_lo} (short) to P, then go to HI if long, else DONE.
REQ-021 HI SHALL be one idle cycle (second register write port slot), then go to DONE.
REQ-022 DONE SHALL assert done and drive P onto the result outputs, then return to IDLE.
REQ-023 Latency from the start-accept edge to done SHALL be m+a+l cycles, where m = MULT iterations (1..4), a = accumulate, l = long; done is high in the cycle after the last state.
REQ-024 flag_n SHALL be P[31] (short) or P[63] (long); flag_z SHALL be (P[31:0]==0) (short) or (P==0) (long).
REQ-025 start while busy SHALL be ignored with no effect on state.
REQ-026 abort in any non-IDLE state SHALL return to IDLE next cycle with no done pulse; abort takes priority over start in the same cycle.
REQ-027 Outside DONE, done SHALL be 0 and result/flag outputs SHALL hold their last values.

Reset
REQ-028 rst SHALL force IDLE, P=0, i=0, busy=0, done=0, result_lo=result_hi=0, flag_n=flag_z=0 immediately, including mid-operation.

Configuration
REQ-029 With ARM_MUL_EARLY_TERM_EN defined, early termination per REQ-017 SHALL apply. Without it, MULT SHALL always run 4 iterations with chunk 3 signed for signed-rule ops, and results SHALL be unchanged.

Structure
REQ-030 arm7tdmi_pkg SHALL hold mul_op_e, the mul_state_e enum, and MUL_CHUNK_W=8.
REQ-031 One combinational sub-module, arm7tdmi_mul_step, SHALL compute P + ((A*chunk)<<8i) with a chunk-signed control.

Verification
REQ-032 MUL: op_a=5, op_b=7 -> m=1, done 2 cycles after start, lo=35, N=0, Z=0.
REQ-033 MLA: 5,7, acc_lo=35 -> done at cycle 3, lo=70; MUL 0*9 -> Z=1.
REQ-034 UMULL: 0xFFFF*0xFFFF -> m=2, done at cycle 4, hi=0x00000000, lo=0xFFFE0001.
REQ-035 op_a=0xFFFFFFFF, op_b=0xFFFFFFFE. SMULL -> m=1, result 0x00000000_00000002. UMULL -> m=4, result 0xFFFFFFFD_00000002. Without the macro, SMULL takes m=4 with the same result.
REQ-036 SMLAL: 0xFFFF*0xFFFF plus acc 0xFFFFFFFF_FFFFFFFF -> result 0x00000000_FFFE0000, N=0, Z=0.
REQ-037 abort during MULT -> IDLE next cycle with no done. start while busy -> ignored. rst during ACC -> all outputs 0 immediately.
